spwm_pwm_multi: RTL

Multi-channel PWM generator and the parametrised successor of the single-channel compare/counter PWM. All channels share one period counter, which runs edge-aligned (sawtooth) or center-aligned (triangle). Each channel has a double-buffered duty register that updates only at a period boundary. Each channel drives a complementary high/low output pair with programmable dead-time, for half-bridge legs in the SPWM inverter path.

---
 rtl/spwm_pwm_multi_if.sv | 34 +++
 rtl/spwm_pwm_multi.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/spwm_pwm_multi_if.sv
// Control and gate-drive bundle for the multi-channel PWM generator.
//   e          : enable; low freezes the generator
//   mode       : 0 = edge-aligned, 1 = center-aligned (taken at the next boundary)
//   duty       : packed per-channel duty, channel k at [k*WIDTH +: WIDTH]
//   load       : one-cycle strobe capturing duty into the pending buffer
//   dead_time  : dead-time in clk cycles, shared by all channels
//   pwm_h/l    : complementary high/low side gate outputs per channel
//   carry      : one-cycle pulse on the period boundary cycle
//   update_ack : one-cycle pulse when pending duties become active
interface spwm_pwm_multi_if #(
  parameter int WIDTH    = 14,
  parameter int CHANNELS = 3,
  parameter int DT_WIDTH = 8
);
  logic                      e;
  logic                      mode;
  logic [CHANNELS*WIDTH-1:0] duty;
  logic                      load;
  logic [DT_WIDTH-1:0]       dead_time;
  logic [CHANNELS-1:0]       pwm_h;
  logic [CHANNELS-1:0]       pwm_l;
  logic                      carry;
  logic                      update_ack;

  modport master (
    output e, mode, duty, load, dead_time,
    input  pwm_h, pwm_l, carry, update_ack
  );

  modport slave (
    input  e, mode, duty, load, dead_time,
    output pwm_h, pwm_l, carry, update_ack
  );
endinterface

// File: rtl/spwm_pwm_multi.sv
// Multi-channel PWM generator with a shared edge/center-aligned period
// counter, double-buffered duty registers and per-channel dead-time.
//   clk     : system clock, rising edge
//   rst_syn : synchronous active-high reset, priority over enable
//   bus     : spwm_pwm_multi_if slave (controls in, gate outputs out)
//
// Counter direction FSM:
//   state  | meaning
//   DIR_UP | counting up (always the case in edge-aligned mode)
//   DIR_DN | center-aligned down-slope, PERIOD-2 down to 1
module spwm_pwm_multi #(
  parameter int WIDTH    = 14,
  parameter int PERIOD   = 10000,
  parameter int CHANNELS = 3,
  parameter int DT_WIDTH = 8
) (
  input logic              clk,
  input logic              rst_syn,
  spwm_pwm_multi_if.slave  bus
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DN = 1'b1} dir_t;

  localparam logic [WIDTH-1:0]    CNT_TOP  = WIDTH'(PERIOD - 1);
  localparam logic [WIDTH-1:0]    CNT_TURN = WIDTH'(PERIOD - 2);
  localparam logic [WIDTH-1:0]    CNT_ONE  = WIDTH'(1);
  localparam logic [DT_WIDTH-1:0] DT_ONE   = DT_WIDTH'(1);

  logic [WIDTH-1:0]    cnt_q, cnt_d;
  dir_t                dir_q, dir_d;
  logic                mode_act_q, mode_act_d;
  logic                boundary;

  logic [WIDTH-1:0]    act_q  [CHANNELS];
  logic [WIDTH-1:0]    pend_q [CHANNELS];
  logic                pend_vld_q;
  logic                ack_q;

  logic [CHANNELS-1:0] raw;
  logic [CHANNELS-1:0] tgt_q, tgt_d;
  logic [DT_WIDTH-1:0] dt_q [CHANNELS];
  logic [DT_WIDTH-1:0] dt_d [CHANNELS];
  logic [CHANNELS-1:0] h_q, h_d;
  logic [CHANNELS-1:0] l_q, l_d;

  // Counter / direction next-state
  always_comb begin
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    mode_act_d = mode_act_q;
    boundary   = mode_act_q ? (dir_q == DIR_DN && cnt_q == CNT_ONE)
                            : (cnt_q == CNT_TOP);
    if (bus.e) begin
      if (boundary) begin
        cnt_d      = '0;
        dir_d      = DIR_UP;
        mode_act_d = bus.mode;
      end else if (!mode_act_q) begin
        cnt_d = cnt_q + CNT_ONE;
      end else if (dir_q == DIR_UP) begin
        // Peak is visited once; the turn lands directly on PERIOD-2.
        if (cnt_q == CNT_TOP) begin
          dir_d = DIR_DN;
          cnt_d = CNT_TURN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  // Compare and dead-time next-state; outputs settle once the
  // down-counter's next value is zero, so dead_time=0 gives a 1-cycle lag.
  always_comb begin
    raw   = '0;
    tgt_d = tgt_q;
    h_d   = h_q;
    l_d   = l_q;
    for (int k = 0; k < CHANNELS; k++) begin
      dt_d[k] = dt_q[k];
      raw[k]  = (cnt_q < act_q[k]);
      if (bus.e) begin
        if (raw[k] != tgt_q[k]) begin
          tgt_d[k] = raw[k];
          dt_d[k]  = bus.dead_time;
        end else if (dt_q[k] != '0) begin
          dt_d[k] = dt_q[k] - DT_ONE;
        end
        h_d[k] = (dt_d[k] == '0) &  tgt_d[k];
        l_d[k] = (dt_d[k] == '0) & ~tgt_d[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_syn) begin
      cnt_q      <= '0;
      dir_q      <= DIR_UP;
      mode_act_q <= 1'b0;
      pend_vld_q <= 1'b0;
      ack_q      <= 1'b0;
      tgt_q      <= '0;
      h_q        <= '0;
      l_q        <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        act_q[k]  <= '0;
        pend_q[k] <= '0;
        dt_q[k]   <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      mode_act_q <= mode_act_d;
      tgt_q      <= tgt_d;
      h_q        <= h_d;
      l_q        <= l_d;
      for (int k = 0; k < CHANNELS; k++) begin
        dt_q[k] <= dt_d[k];
      end
      if (bus.e) begin
        ack_q <= boundary & pend_vld_q;
      end
      if (bus.e && boundary && pend_vld_q) begin
        for (int k = 0; k < CHANNELS; k++) begin
          act_q[k] <= pend_q[k];
        end
      end
      // A load on the boundary cycle stays pending for the next period.
      if (bus.load) begin
        for (int k = 0; k < CHANNELS; k++) begin
          pend_q[k] <= bus.duty[k*WIDTH +: WIDTH];
        end
        pend_vld_q <= 1'b1;
      end else if (bus.e && boundary) begin
        pend_vld_q <= 1'b0;
      end
    end
  end

  assign bus.pwm_h      = h_q;
  assign bus.pwm_l      = l_q;
  assign bus.carry      = bus.e & boundary;
  assign bus.update_ack = bus.e & ack_q;

endmodule
